nios2_pio_poller: RTL and testbench

Avalon-MM master that polls a read-only PIO slave, such as the switch input port, at a fixed period. It filters each sampled value for stability and delivers every settled change as a single event on a valid/ready stream. It sits between the PIO slave's s1 port and fabric logic, such as the ambilight mode/config path, that needs switch changes without involving the Nios II.

---
 rtl/nios2_pio_poller.sv | 78 +++++++
 tb/tb_nios2_pio_poller.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nios2_pio_poller.sv
// nios2_pio_poller: periodic Avalon-MM PIO poller with stability filter and valid/ready event stream
module nios2_pio_poller #(
    parameter int DATA_W       = 18,
    parameter int POLL_DIV     = 50000,
    parameter int STABLE_CNT   = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        avm_address,
    output logic              avm_read,
    input  logic [31:0]       avm_readdata,
    output logic              src_valid,
    input  logic              src_ready,
    output logic [DATA_W-1:0] src_data,
    output logic [DATA_W-1:0] stable_value,
    output logic              overrun,
    input  logic              clear_overrun
);
    localparam int TW = $clog2(POLL_DIV);
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam int LW = $clog2(READ_LATENCY + 1);
    localparam logic [TW-1:0] T_LAST = TW'(POLL_DIV - 1);
    localparam logic [CW-1:0] C_MAX  = CW'(STABLE_CNT);
    localparam logic [LW-1:0] L_LAST = LW'(READ_LATENCY - 1);
    typedef enum logic [1:0] {IDLE, READ, WAIT, CHECK} state_t;
    state_t state, state_nx;
    logic [TW-1:0] timer;
    logic [LW-1:0] lat;
    logic [CW-1:0] cnt, cnt_nx;
    logic [DATA_W-1:0] sample, cand;
    logic poll, lat_done, event_hit;
    logic unused_hi;
    assign unused_hi = ^avm_readdata[31:DATA_W];
    // State register
    always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
    // Next state, bus strobes and filter decision
    always_comb begin
        poll        = timer == T_LAST;
        lat_done    = state == WAIT && lat == L_LAST;
        state_nx    = state == IDLE ? (poll ? READ : IDLE) :
                      state == READ ? WAIT :
                      state == WAIT ? (lat_done ? CHECK : WAIT) : IDLE;
        avm_read    = state == READ;
        avm_address = 2'd0;
        cnt_nx      = sample != cand ? CW'(1) : cnt == C_MAX ? C_MAX : cnt + 1'b1;
        event_hit   = state == CHECK && cnt_nx == C_MAX && sample != stable_value;
    end
    // Free-running poll timer and read-latency counter
    always_ff @(posedge clk) begin
        timer <= (reset || poll) ? '0 : timer + 1'b1;
        lat   <= (reset || state != WAIT) ? '0 : lat + 1'b1;
    end
    // Sample capture, stability filter and output stream
    always_ff @(posedge clk) begin
        if (reset) begin
            sample       <= '0;
            cand         <= '0;
            cnt          <= C_MAX;
            stable_value <= '0;
            src_data     <= '0;
            src_valid    <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (lat_done) sample <= avm_readdata[DATA_W-1:0];
            if (state == CHECK) begin
                cand <= sample;
                cnt  <= cnt_nx;
            end
            if (event_hit) begin
                stable_value <= sample;
                src_data     <= sample;
            end
            src_valid <= event_hit | (src_valid & ~src_ready);
            overrun   <= (event_hit & src_valid & ~src_ready) | (overrun & ~clear_overrun);
        end
    end
endmodule

// File: tb/tb_nios2_pio_poller.sv
// tb_nios2_pio_poller: randomized self-checking bench against a sample-window reference model
module tb_nios2_pio_poller;
    localparam int DW = 18, PD = 8, SC = 3, RL = 1;
    logic clk = 0, reset = 1, src_ready = 0, clear_overrun = 0;
    logic [1:0] avm_address;
    logic avm_read, src_valid, overrun;
    logic [31:0] avm_readdata = 0;
    logic [DW-1:0] src_data, stable_value, sw = 0;
    int n_chk = 0, n_err = 0;

    nios2_pio_poller #(.DATA_W(DW), .POLL_DIV(PD), .STABLE_CNT(SC), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .stable_value(stable_value), .overrun(overrun),
        .clear_overrun(clear_overrun)
    );

    always #5 clk = ~clk;
    // PIO slave: registers the switches every clock, upper bits are junk
    always @(posedge clk) avm_readdata <= {14'($urandom), sw};

    // Reference model: cycle index since reset, window of the last SC polled samples
    int cyc = 0, pend_at = -1;
    logic [DW-1:0] hist [SC];
    logic [DW-1:0] pend_s = 0, m_stable = 0, m_data = 0;
    logic m_valid = 0, m_ovr = 0, m_ev, m_set, m_read;
    always @(posedge clk) begin
        if (reset) begin
            cyc = 0; pend_at = -1; m_stable = 0; m_data = 0; m_valid = 0; m_ovr = 0;
            for (int i = 0; i < SC; i++) hist[i] = '0;
        end else begin
            m_ev = 0;
            if (cyc == pend_at) begin
                for (int i = 0; i < SC - 1; i++) hist[i] = hist[i+1];
                hist[SC-1] = pend_s;
                m_ev = pend_s != m_stable;
                for (int i = 0; i < SC; i++) if (hist[i] != pend_s) m_ev = 0;
            end
            m_set = m_ev && m_valid && !src_ready;
            if (m_ev) begin m_stable = pend_s; m_data = pend_s; end
            m_valid = m_ev || (m_valid && !src_ready);
            m_ovr = m_set || (m_ovr && !clear_overrun);
            if (cyc > 0 && cyc % PD == 0) begin pend_s = sw; pend_at = cyc + RL + 1; end
            cyc++;
        end
    end
    assign m_read = cyc > 0 && cyc % PD == 0;

    logic [40:0] obs, expv;
    assign obs  = {avm_read, avm_address, src_valid, src_data, stable_value, overrun};
    assign expv = {m_read, 2'b00, m_valid, m_data, m_stable, m_ovr};

    task automatic test_reset;
        int nr = 0;
        reset = 1; sw = 0; src_ready = 0; clear_overrun = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (obs !== 41'b0) begin n_err++; $display("FAIL reset_values got=%h exp=0", obs); end
        reset = 0;
        repeat (100) begin
            @(negedge clk); nr += int'(avm_read);
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        n_chk++; if (nr !== 12) begin n_err++; $display("FAIL idle_reads got=%0d exp=12", nr); end
    endtask

    task automatic test_step;
        int c0, nev = 0, vcyc = -1;
        logic [DW-1:0] vdata = 0;
        do begin
            @(negedge clk);
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL step_align cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end while (cyc % PD != 1);
        c0 = cyc; sw = 18'h2A5C7; src_ready = 1;
        repeat (40) begin
            @(negedge clk);
            if (src_valid) begin nev++; vcyc = cyc; vdata = src_data; end
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL step cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        n_chk++; if (nev !== 1) begin n_err++; $display("FAIL step_events got=%0d exp=1", nev); end
        n_chk++; if (vcyc !== c0 + 7 + 2 * PD + RL + 2) begin n_err++; $display("FAIL step_time got=%0d exp=%0d", vcyc, c0 + 26); end
        n_chk++; if (vdata !== 18'h2A5C7) begin n_err++; $display("FAIL step_data got=%h exp=2a5c7", vdata); end
        n_chk++; if (stable_value !== 18'h2A5C7) begin n_err++; $display("FAIL step_stable got=%h exp=2a5c7", stable_value); end
    endtask

    task automatic test_bounce;
        int nalt = 0, nev = 0;
        logic [DW-1:0] vdata = 0;
        src_ready = 1;
        for (int k = 0; k < 6; k++) begin
            do begin
                @(negedge clk); nalt += int'(src_valid);
                n_chk++; if (obs !== expv) begin n_err++; $display("FAIL bounce_alt cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            end while (cyc % PD != 1);
            sw = (k % 2 == 0) ? 18'h00001 : 18'h00002;
        end
        repeat (40) begin
            @(negedge clk);
            if (src_valid) begin nev++; vdata = src_data; end
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL bounce cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        n_chk++; if (nalt !== 0) begin n_err++; $display("FAIL bounce_no_event got=%0d exp=0", nalt); end
        n_chk++; if (nev !== 1 || vdata !== 18'h2) begin n_err++; $display("FAIL bounce_settle got=%0d/%h exp=1/2", nev, vdata); end
    endtask

    task automatic test_overrun;
        int nxf = 0;
        src_ready = 0;
        for (int k = 0; k < 2; k++) begin
            do begin
                @(negedge clk);
                n_chk++; if (obs !== expv) begin n_err++; $display("FAIL ovr_align cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            end while (cyc % PD != 1);
            sw = k == 0 ? 18'h00011 : 18'h00022;
            repeat (30) begin
                @(negedge clk);
                n_chk++; if (obs !== expv) begin n_err++; $display("FAIL ovr cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            end
        end
        n_chk++; if ({src_valid, src_data, overrun} !== {1'b1, 18'h00022, 1'b1}) begin
            n_err++; $display("FAIL ovr_set got=%b/%h/%b exp=1/00022/1", src_valid, src_data, overrun); end
        src_ready = 1;
        for (int i = 0; i < 3; i++) begin
            nxf += int'(src_valid & src_ready);
            @(negedge clk);
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL ovr_xfer cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        src_ready = 0;
        n_chk++; if (nxf !== 1 || src_valid !== 1'b0) begin n_err++; $display("FAIL ovr_transfer got=%0d/%b exp=1/0", nxf, src_valid); end
        clear_overrun = 1;
        @(negedge clk);
        clear_overrun = 0;
        n_chk++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_back_to_back;
        int c0;
        src_ready = 0;
        for (int k = 0; k < 3; k++) begin
            do begin
                @(negedge clk);
                n_chk++; if (obs !== expv) begin n_err++; $display("FAIL b2b_align cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            end while (cyc % PD != 1);
            c0 = cyc;
            sw = k == 0 ? 18'h00155 : k == 1 ? 18'h003AB : 18'h00F0F;
            while (cyc != c0 + 7 + 2 * PD + RL + 1) begin
                @(negedge clk);
                n_chk++; if (obs !== expv) begin n_err++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            end
            src_ready = k == 1;
            clear_overrun = k == 2;
            @(negedge clk);
            src_ready = 0; clear_overrun = 0;
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL b2b_edge cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        n_chk++; if ({src_valid, src_data, overrun} !== {1'b1, 18'h00F0F, 1'b1}) begin
            n_err++; $display("FAIL b2b_set_wins got=%b/%h/%b exp=1/00f0f/1", src_valid, src_data, overrun); end
    endtask

    task automatic test_reset_mid;
        int first = 0;
        n_chk++; if (src_valid !== 1'b1) begin n_err++; $display("FAIL rmid_pending got=%b exp=1", src_valid); end
        do begin
            @(negedge clk);
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL rmid_align cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end while (cyc % PD != 1);
        reset = 1;
        @(negedge clk);
        n_chk++; if (obs !== 41'b0) begin n_err++; $display("FAIL rmid_zero got=%h exp=0", obs); end
        reset = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (avm_read && first == 0) first = i;
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL rmid cyc=%0d got=%h exp=%h", cyc, obs, expv); end
        end
        n_chk++; if (first !== PD) begin n_err++; $display("FAIL rmid_first_read got=%0d exp=%0d", first, PD); end
    endtask

    task automatic test_random;
        logic [DW-1:0] pats [4];
        pats[0] = 18'h00001; pats[1] = 18'h00002; pats[2] = 18'h3FFFF; pats[3] = 18'h2A5C7;
        repeat (1500) begin
            @(negedge clk);
            n_chk++; if (obs !== expv) begin n_err++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, obs, expv); end
            if ($urandom_range(0, 29) == 0) sw = pats[$urandom_range(0, 3)];
            src_ready = 1'($urandom_range(0, 1));
            clear_overrun = $urandom_range(0, 15) == 0;
            reset = $urandom_range(0, 399) == 0;
        end
        @(negedge clk);
        reset = 0; src_ready = 0; clear_overrun = 0;
    endtask

    initial begin
        test_reset();
        test_step();
        test_bounce();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
